// File: rtl/mem_write_responder_if.sv
// mem_write_responder_if: client line-write handshake bundle (request, line data, burst descriptor, grant).
interface mem_write_responder_if #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19
);
    localparam int LINE_BYTES = WORD_WIDTH*NUM_WORDS_IN_LINE/8;
    logic mem_req;
    logic mem_gnt;
    logic last;
    logic [ADDR_WIDTH-1:0] mem_start_addr;
    logic [ADDR_WIDTH-ADDR_WIDTH/8-1:0] mem_size_bytes;
    logic [WORD_WIDTH*NUM_WORDS_IN_LINE-1:0] mem_data;
    logic [$clog2(LINE_BYTES)-1:0] mem_last_valid;
    modport master(output mem_req, last, mem_start_addr, mem_size_bytes, mem_data, mem_last_valid, input mem_gnt);
    modport slave(input mem_req, last, mem_start_addr, mem_size_bytes, mem_data, mem_last_valid, output mem_gnt);
endinterface

// File: rtl/mem_write_responder.sv
// mem_write_responder: accepts line bursts from a client and writes them to a line-wide SRAM with byte enables.
// Optional MEM_WR_RESP_STATS_EN adds saturating granted-line and errored-burst counters.
module mem_write_responder #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19,
    localparam int LINE_W     = WORD_WIDTH*NUM_WORDS_IN_LINE,
    localparam int LINE_BYTES = LINE_W/8,
    localparam int LB_W       = $clog2(LINE_BYTES),
    localparam int LINE_AW    = ADDR_WIDTH-LB_W,
    localparam int SIZE_W     = ADDR_WIDTH-ADDR_WIDTH/8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_write_responder_if.slave  bus,
    input  logic                  i_sram_ready,
    output logic                  o_sram_we,
    output logic [LINE_AW-1:0]    o_sram_addr,
    output logic [LINE_W-1:0]     o_sram_wdata,
    output logic [LINE_BYTES-1:0] o_sram_be,
    output logic                  o_wr_done,
    output logic                  o_wr_err
`ifdef MEM_WR_RESP_STATS_EN
    ,
    output logic [31:0]           o_stat_lines,
    output logic [15:0]           o_stat_errs
`endif
);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t r_state, w_next;
    logic [LINE_AW-1:0] r_line_ptr;
    logic [SIZE_W-1:0] r_rem;
    logic r_zero;
    logic w_start, w_gnt, w_small, w_err;
    logic [LINE_BYTES-1:0] w_be;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_start = (r_state == IDLE) & bus.mem_req;
        w_gnt = (r_state == WRITE) & bus.mem_req & i_sram_ready;
        w_next = w_start ? WRITE : (w_gnt & bus.last) ? IDLE : r_state;
    end
    assign bus.mem_gnt = w_gnt;
    assign w_small = r_rem <= SIZE_W'(LINE_BYTES);
    // Expected last index is (rem-1) mod LINE_BYTES, taken from the low bits only
    assign w_err = bus.last ? (!w_small | (bus.mem_last_valid != r_rem[LB_W-1:0] - LB_W'(1))) : w_small;
    always_comb begin
        w_be = '0;
        for (int i = 0; i < LINE_BYTES; i++) w_be[i] = !r_zero & (!bus.last | (i <= int'(bus.mem_last_valid)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_ptr   <= '0;
            r_rem        <= '0;
            r_zero       <= 1'b0;
            o_sram_we    <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_be    <= '0;
            o_wr_done    <= 1'b0;
            o_wr_err     <= 1'b0;
        end else begin
            o_sram_we <= w_gnt;
            o_wr_done <= w_gnt & bus.last;
            if (w_start) begin
                r_line_ptr <= bus.mem_start_addr[ADDR_WIDTH-1:LB_W];
                r_rem      <= bus.mem_size_bytes;
                r_zero     <= bus.mem_size_bytes == '0;
                o_wr_err   <= (|bus.mem_start_addr[LB_W-1:0]) | (bus.mem_size_bytes == '0);
            end
            if (w_gnt) begin
                o_sram_addr  <= r_line_ptr;
                o_sram_wdata <= bus.mem_data;
                o_sram_be    <= w_be;
                r_line_ptr   <= r_line_ptr + LINE_AW'(1);
                r_rem        <= w_small ? '0 : r_rem - SIZE_W'(LINE_BYTES);
                o_wr_err     <= o_wr_err | w_err;
            end
        end
    end
`ifdef MEM_WR_RESP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stat_lines <= '0;
            o_stat_errs  <= '0;
        end else begin
            if (w_gnt && o_stat_lines != '1) o_stat_lines <= o_stat_lines + 32'd1;
            if (w_gnt && bus.last && (o_wr_err | w_err) && o_stat_errs != '1) o_stat_errs <= o_stat_errs + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_write_responder.sv
// tb_mem_write_responder: directed self-checking bench for mem_write_responder.
// Honours MEM_WR_RESP_STATS_EN to also check the line counter.
module tb_mem_write_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sram_ready = 1'b1;
    logic sram_we, wr_done, wr_err;
    logic [13:0] sram_addr;
    logic [255:0] sram_wdata;
    logic [31:0] sram_be;
    int checks = 0;
    int failures = 0;
`ifdef MEM_WR_RESP_STATS_EN
    logic [31:0] stat_lines;
    logic [15:0] stat_errs;
`endif
    mem_write_responder_if bus_if();
    mem_write_responder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if),
        .i_sram_ready(sram_ready),
        .o_sram_we(sram_we),
        .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata),
        .o_sram_be(sram_be),
        .o_wr_done(wr_done),
        .o_wr_err(wr_err)
`ifdef MEM_WR_RESP_STATS_EN
        ,
        .o_stat_lines(stat_lines),
        .o_stat_errs(stat_errs)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic req, input logic lst, input logic [4:0] lv, input logic [255:0] d);
        bus_if.mem_req = req;
        bus_if.last = lst;
        bus_if.mem_last_valid = lv;
        bus_if.mem_data = d;
        #1;
    endtask
    initial begin
        bus_if.mem_req = 1'b0;
        bus_if.last = 1'b0;
        bus_if.mem_start_addr = '0;
        bus_if.mem_size_bytes = '0;
        bus_if.mem_data = '0;
        bus_if.mem_last_valid = '0;
        step();
        step();
        chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_be", sram_be, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_err", wr_err, 0);
        chk("rst_gnt", bus_if.mem_gnt, 0);
        rst = 1'b0;
        step();
        // 3-line aligned burst at line 2
        bus_if.mem_start_addr = 19'h00040;
        bus_if.mem_size_bytes = 17'd96;
        drive(1, 0, 0, {8{32'h1111_0001}});
        chk("t1_idle_gnt", bus_if.mem_gnt, 0);
        step();
        chk("t1_gnt1", bus_if.mem_gnt, 1);
        step();
        chk("t1_we1", sram_we, 1);
        chk("t1_addr1", sram_addr, 2);
        chk("t1_data1", sram_wdata, {8{32'h1111_0001}});
        chk("t1_be1", sram_be, 32'hFFFF_FFFF);
        chk("t1_done1", wr_done, 0);
        drive(1, 0, 0, {8{32'h1111_0002}});
        chk("t1_gnt2", bus_if.mem_gnt, 1);
        step();
        chk("t1_addr2", sram_addr, 3);
        drive(1, 1, 31, {8{32'h1111_0003}});
        chk("t1_gnt3", bus_if.mem_gnt, 1);
        step();
        chk("t1_we3", sram_we, 1);
        chk("t1_addr3", sram_addr, 4);
        chk("t1_be3", sram_be, 32'hFFFF_FFFF);
        chk("t1_done3", wr_done, 1);
        chk("t1_err", wr_err, 0);
        drive(0, 0, 0, 0);
        step();
        chk("t1_we_off", sram_we, 0);
        chk("t1_done_off", wr_done, 0);
        // 40-byte burst: partial final line
        bus_if.mem_start_addr = 19'h00100;
        bus_if.mem_size_bytes = 17'd40;
        drive(1, 0, 0, {8{32'h2222_0001}});
        step();
        step();
        chk("t2_addr1", sram_addr, 8);
        chk("t2_be1", sram_be, 32'hFFFF_FFFF);
        drive(1, 1, 7, {8{32'h2222_0002}});
        step();
        chk("t2_addr2", sram_addr, 9);
        chk("t2_be2", sram_be, 32'h0000_00FF);
        chk("t2_done", wr_done, 1);
        chk("t2_err", wr_err, 0);
        drive(0, 0, 0, 0);
        step();
        // sram_ready stalls
        bus_if.mem_start_addr = 19'h00200;
        bus_if.mem_size_bytes = 17'd64;
        drive(1, 0, 0, {8{32'h3333_0001}});
        step();
        chk("t3_gnt1", bus_if.mem_gnt, 1);
        step();
        chk("t3_we1", sram_we, 1);
        chk("t3_addr1", sram_addr, 16);
        chk("t3_data1", sram_wdata, {8{32'h3333_0001}});
        sram_ready = 1'b0;
        drive(1, 1, 31, {8{32'h3333_0002}});
        chk("t3_stall_gnt_a", bus_if.mem_gnt, 0);
        step();
        chk("t3_stall_we_a", sram_we, 0);
        chk("t3_stall_gnt_b", bus_if.mem_gnt, 0);
        step();
        chk("t3_stall_we_b", sram_we, 0);
        sram_ready = 1'b1;
        #1;
        chk("t3_gnt2", bus_if.mem_gnt, 1);
        step();
        chk("t3_we2", sram_we, 1);
        chk("t3_addr2", sram_addr, 17);
        chk("t3_data2", sram_wdata, {8{32'h3333_0002}});
        chk("t3_done", wr_done, 1);
        chk("t3_err", wr_err, 0);
        drive(0, 0, 0, 0);
        step();
        chk("t3_no_dup", sram_we, 0);
        // early last: error, sticky until next burst
        bus_if.mem_start_addr = 19'h00400;
        bus_if.mem_size_bytes = 17'd64;
        drive(1, 1, 31, {8{32'h4444_0001}});
        step();
        step();
        chk("t4_we", sram_we, 1);
        chk("t4_addr", sram_addr, 32);
        chk("t4_done", wr_done, 1);
        chk("t4_err", wr_err, 1);
        drive(0, 0, 0, 0);
        chk("t4_idle_gnt", bus_if.mem_gnt, 0);
        step();
        chk("t4_err_sticky", wr_err, 1);
        // next burst clears the error, then reset lands mid-burst
        bus_if.mem_start_addr = 19'h00800;
        bus_if.mem_size_bytes = 17'd96;
        drive(1, 0, 0, {8{32'h5555_0001}});
        step();
        chk("t5_err_clr", wr_err, 0);
        step();
        chk("t5_addr1", sram_addr, 64);
        rst = 1'b1;
        #1;
        chk("t5_rst_we", sram_we, 0);
        chk("t5_rst_addr", sram_addr, 0);
        chk("t5_rst_wdata", sram_wdata, 0);
        chk("t5_rst_gnt", bus_if.mem_gnt, 0);
        step();
        chk("t5_rst_we2", sram_we, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        step();
        chk("t5_post_we", sram_we, 0);
        // wrap at top line
        bus_if.mem_start_addr = 19'h7FFE0;
        bus_if.mem_size_bytes = 17'd64;
        drive(1, 0, 0, {8{32'h6666_0001}});
        step();
        step();
        chk("t6_addr1", sram_addr, 14'h3FFF);
        drive(1, 1, 31, {8{32'h6666_0002}});
        step();
        chk("t6_addr2", sram_addr, 14'h0000);
        chk("t6_done", wr_done, 1);
        chk("t6_err", wr_err, 0);
`ifdef MEM_WR_RESP_STATS_EN
        chk("t6_stat_lines", stat_lines, 2);
        chk("t6_stat_errs", stat_errs, 0);
`endif
        drive(0, 0, 0, 0);
        step();
        // zero-size burst: error, no bytes enabled
        bus_if.mem_start_addr = 19'h00020;
        bus_if.mem_size_bytes = 17'd0;
        drive(1, 1, 0, {8{32'h7777_0001}});
        step();
        chk("t7_err_start", wr_err, 1);
        step();
        chk("t7_we", sram_we, 1);
        chk("t7_addr", sram_addr, 1);
        chk("t7_be", sram_be, 0);
        chk("t7_err", wr_err, 1);
`ifdef MEM_WR_RESP_STATS_EN
        chk("t7_stat_errs", stat_errs, 1);
`endif
        drive(0, 0, 0, 0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
